// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the 16-bit accumulator datapath.
// Decodes IR[15:12] and steps through fetch, decode, execute, memory and
// writeback one state per clock. It closes the loop on isZero and, when
// enabled, on overflow_out.
// Optional build macro: CTRL_ILLEGAL_TRAP_EN. When it is defined, opcodes
// 0xB-0xE and ADD/SUB/ADDI overflow send the FSM to TRAP. When it is
// undefined, 0xB-0xE retire as NOPs and overflow is ignored.
// Outputs are a Moore decode of the state register. DECODE also looks at
// opcode, and BRANCH passes isZero through. All outputs are forced to 0
// while Reset is high, so no strobe can fire in a reset cycle.
module multicycle_control_unit #(
    parameter int unsigned FETCH_WAIT = 0
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] opcode,
    input  logic       isZero,
    input  logic       overflow_out,
    output logic       IR_Write,
    output logic       PC_Write,
    output logic       PC_Src,
    output logic       ItypeSel,
    output logic       Asel,
    output logic       Bsel,
    output logic       Awrite,
    output logic       Bwrite,
    output logic [2:0] ALUcontrol,
    output logic       ALUOutWrite,
    output logic       iszero_write,
    output logic       reg_write,
    output logic [1:0] destAddr,
    output logic [2:0] destData,
    output logic       Mwrite,
    output logic       Mread,
    output logic       instr_done,
    output logic       halted,
    output logic [3:0] state_dbg
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(FETCH_WAIT);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LI   = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_BEQZ = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_MOVE = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD   = 3'd1;
    localparam logic [2:0] DD_ALUOUT = 3'd0;
    localparam logic [2:0] DD_A      = 3'd3;
    localparam logic [2:0] DD_MEM    = 3'd4;
    localparam logic [2:0] DD_IMM    = 3'd5;
    localparam logic [1:0] DEST_REG  = 2'd0;
    localparam logic [1:0] DEST_ACC  = 2'd1;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_MOVE     = 4'd11,
        S_LOAD_IMM = 4'd12,
        S_HALT     = 4'd13,
        S_TRAP     = 4'd14
    } state_e;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam state_e ILLEGAL_DEST   = S_TRAP;
    localparam logic   ILLEGAL_IS_NOP = 1'b0;
`else
    localparam state_e ILLEGAL_DEST   = S_FETCH;
    localparam logic   ILLEGAL_IS_NOP = 1'b1;
`endif

    state_e            state_q;
    logic [CNT_W-1:0]  fetch_cnt_q;
    logic              phase_q;      // 0 = operand-load cycle, 1 = ALU cycle
    logic              fetch_last_c;
    logic              illegal_op_c;
    logic              ovf_trap_c;
    logic [2:0]        alu_r_op_c;

    assign fetch_last_c = (fetch_cnt_q == FETCH_LAST);
    assign illegal_op_c = (opcode >= 4'hB) && (opcode <= 4'hE);
    // R-type ALU op code is opcode+1 (ADD=1, SUB=2, AND=3, OR=4)
    assign alu_r_op_c   = 3'({1'b0, opcode[1:0]}) + 3'd1;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign ovf_trap_c = overflow_out &&
                        ((opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_ADDI));
`else
    logic unused_overflow;
    assign unused_overflow = overflow_out;
    assign ovf_trap_c      = 1'b0;
`endif

    // Dispatch target for legal opcodes; illegal opcodes are handled separately
    function automatic state_e decode_target(input logic [3:0] op);
        state_e nxt;
        nxt = S_FETCH;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: nxt = S_EXEC_R;
            OP_ADDI:                       nxt = S_EXEC_I;
            OP_LI:                         nxt = S_LOAD_IMM;
            OP_LW, OP_SW:                  nxt = S_MEM_ADDR;
            OP_BEQZ:                       nxt = S_BRANCH;
            OP_JMP:                        nxt = S_JUMP;
            OP_MOVE:                       nxt = S_MOVE;
            OP_HALT:                       nxt = S_HALT;
            default:                       nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

    // State register, fetch wait counter and two-cycle phase bit
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_FETCH;
            fetch_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (fetch_last_c) begin
                        fetch_cnt_q <= '0;
                        state_q     <= S_DECODE;
                    end else begin
                        fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    phase_q <= 1'b0;
                    state_q <= illegal_op_c ? ILLEGAL_DEST : decode_target(opcode);
                end
                S_EXEC_R, S_EXEC_I: begin
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                        state_q <= ovf_trap_c ? S_TRAP : S_ALU_WB;
                    end
                end
                S_MEM_ADDR: begin
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                        state_q <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                    end
                end
                S_MEM_RD: state_q <= S_MEM_WB;
                S_ALU_WB, S_MEM_WB, S_MEM_WR, S_BRANCH,
                S_JUMP, S_MOVE, S_LOAD_IMM: state_q <= S_FETCH;
                S_HALT:   state_q <= S_HALT;
                S_TRAP:   state_q <= S_TRAP;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    // Moore output decode, gated to all-zero while Reset is asserted
    always_comb begin
        IR_Write     = 1'b0;
        PC_Write     = 1'b0;
        PC_Src       = 1'b0;
        ItypeSel     = 1'b0;
        Asel         = 1'b0;
        Bsel         = 1'b0;
        Awrite       = 1'b0;
        Bwrite       = 1'b0;
        ALUcontrol   = 3'd0;
        ALUOutWrite  = 1'b0;
        iszero_write = 1'b0;
        reg_write    = 1'b0;
        destAddr     = 2'd0;
        destData     = 3'd0;
        Mwrite       = 1'b0;
        Mread        = 1'b0;
        instr_done   = 1'b0;
        halted       = 1'b0;
        state_dbg    = 4'd0;
        if (!Reset) begin
            state_dbg = 4'(state_q);
            case (state_q)
                S_FETCH: begin
                    IR_Write = fetch_last_c;
                    PC_Write = fetch_last_c;
                end
                S_DECODE: begin
                    Asel       = 1'b1;
                    Awrite     = 1'b1;
                    instr_done = illegal_op_c & ILLEGAL_IS_NOP;
                end
                S_EXEC_R: begin
                    if (!phase_q) begin
                        Bwrite = 1'b1;
                    end else begin
                        ALUcontrol   = alu_r_op_c;
                        ALUOutWrite  = 1'b1;
                        iszero_write = 1'b1;
                    end
                end
                S_EXEC_I: begin
                    if (!phase_q) begin
                        Bsel   = 1'b1;
                        Bwrite = 1'b1;
                    end else begin
                        ALUcontrol   = ALU_ADD;
                        ALUOutWrite  = 1'b1;
                        iszero_write = 1'b1;
                    end
                end
                S_ALU_WB: begin
                    reg_write  = 1'b1;
                    destAddr   = DEST_ACC;
                    destData   = DD_ALUOUT;
                    instr_done = 1'b1;
                end
                S_LOAD_IMM: begin
                    reg_write  = 1'b1;
                    destAddr   = DEST_ACC;
                    destData   = DD_IMM;
                    instr_done = 1'b1;
                end
                S_MOVE: begin
                    reg_write  = 1'b1;
                    destAddr   = DEST_REG;
                    destData   = DD_A;
                    instr_done = 1'b1;
                end
                S_MEM_ADDR: begin
                    if (!phase_q) begin
                        Bsel   = 1'b1;
                        Bwrite = 1'b1;
                    end else begin
                        ALUcontrol  = ALU_ADD;
                        ALUOutWrite = 1'b1;
                    end
                end
                S_MEM_RD: begin
                    Mread = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    destAddr   = DEST_ACC;
                    destData   = DD_MEM;
                    instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    Mwrite     = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    PC_Src     = 1'b1;
                    PC_Write   = isZero;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    ItypeSel   = 1'b1;
                    PC_Src     = 1'b1;
                    PC_Write   = 1'b1;
                    instr_done = 1'b1;
                end
                S_HALT, S_TRAP: begin
                    halted = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit.
// The reference model gives, for each opcode, the cycle count and the number
// of times each strobe fires per instruction, plus the write-back selects.
// Tasks are entered and left 1 time unit after a rising edge, at the start of
// an instruction's first FETCH cycle.
module tb_multicycle_control_unit;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [3:0] opcode;
    logic       isZero;
    logic       overflow_out;

    logic       IR_Write, PC_Write, PC_Src, ItypeSel, Asel, Bsel, Awrite, Bwrite;
    logic [2:0] ALUcontrol;
    logic       ALUOutWrite, iszero_write, reg_write;
    logic [1:0] destAddr;
    logic [2:0] destData;
    logic       Mwrite, Mread, instr_done, halted;
    logic [3:0] state_dbg;

    logic       f3_IR_Write, f3_PC_Write, f3_PC_Src, f3_ItypeSel, f3_Asel, f3_Bsel;
    logic       f3_Awrite, f3_Bwrite;
    logic [2:0] f3_ALUcontrol;
    logic       f3_ALUOutWrite, f3_iszero_write, f3_reg_write;
    logic [1:0] f3_destAddr;
    logic [2:0] f3_destData;
    logic       f3_Mwrite, f3_Mread, f3_instr_done, f3_halted;
    logic [3:0] f3_state_dbg;

    logic [26:0] all_out;
    logic [8:0]  strobes;

    int n_tests = 0;
    int n_fail  = 0;

    assign all_out = {IR_Write, PC_Write, PC_Src, ItypeSel, Asel, Bsel, Awrite, Bwrite,
                      ALUcontrol, ALUOutWrite, iszero_write, reg_write, destAddr, destData,
                      Mwrite, Mread, instr_done, halted, state_dbg};
    assign strobes = {IR_Write, PC_Write, Awrite, Bwrite, ALUOutWrite, iszero_write,
                      reg_write, Mwrite, Mread};

    multicycle_control_unit #(.FETCH_WAIT(0)) u_dut (
        .Clock(Clock), .Reset(Reset), .opcode(opcode), .isZero(isZero),
        .overflow_out(overflow_out),
        .IR_Write(IR_Write), .PC_Write(PC_Write), .PC_Src(PC_Src), .ItypeSel(ItypeSel),
        .Asel(Asel), .Bsel(Bsel), .Awrite(Awrite), .Bwrite(Bwrite),
        .ALUcontrol(ALUcontrol), .ALUOutWrite(ALUOutWrite), .iszero_write(iszero_write),
        .reg_write(reg_write), .destAddr(destAddr), .destData(destData),
        .Mwrite(Mwrite), .Mread(Mread), .instr_done(instr_done), .halted(halted),
        .state_dbg(state_dbg)
    );

    multicycle_control_unit #(.FETCH_WAIT(3)) u_dut_fw3 (
        .Clock(Clock), .Reset(Reset), .opcode(opcode), .isZero(isZero),
        .overflow_out(overflow_out),
        .IR_Write(f3_IR_Write), .PC_Write(f3_PC_Write), .PC_Src(f3_PC_Src),
        .ItypeSel(f3_ItypeSel), .Asel(f3_Asel), .Bsel(f3_Bsel), .Awrite(f3_Awrite),
        .Bwrite(f3_Bwrite), .ALUcontrol(f3_ALUcontrol), .ALUOutWrite(f3_ALUOutWrite),
        .iszero_write(f3_iszero_write), .reg_write(f3_reg_write), .destAddr(f3_destAddr),
        .destData(f3_destData), .Mwrite(f3_Mwrite), .Mread(f3_Mread),
        .instr_done(f3_instr_done), .halted(f3_halted), .state_dbg(f3_state_dbg)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int cycles;
        int ir_w, pc_w, pc_src;
        int rw, mw, mr;
        int aluw, izw, done;
        int dd, da, aluc;
    } exp_t;

    // Expected per-instruction behaviour for FETCH_WAIT = 0
    function automatic exp_t model(input logic [3:0] op, input logic iz);
        exp_t e;
        int   body;
        e.ir_w = 1; e.pc_w = 1; e.pc_src = 0; e.rw = 0; e.mw = 0; e.mr = 0;
        e.aluw = 0; e.izw = 0; e.done = 1; e.dd = -1; e.da = -1; e.aluc = -1;
        body = 0;
        if (op <= 4'h3) begin
            body = 3; e.rw = 1; e.dd = 0; e.da = 1; e.aluw = 1; e.izw = 1;
            e.aluc = int'(op) + 1;
        end else begin
            case (op)
                4'h4: begin body = 3; e.rw = 1; e.dd = 0; e.da = 1; e.aluw = 1; e.izw = 1; e.aluc = 1; end
                4'h5: begin body = 1; e.rw = 1; e.dd = 5; e.da = 1; end
                4'h6: begin body = 4; e.rw = 1; e.dd = 4; e.da = 1; e.aluw = 1; e.aluc = 1; e.mr = 1; end
                4'h7: begin body = 3; e.mw = 1; e.aluw = 1; e.aluc = 1; end
                4'h8: begin body = 1; e.pc_src = 1; e.pc_w = iz ? 2 : 1; end
                4'h9: begin body = 1; e.pc_src = 1; e.pc_w = 2; end
                4'hA: begin body = 1; e.rw = 1; e.dd = 3; e.da = 0; end
                default: body = 0;
            endcase
        end
        e.cycles = 2 + body;
        return e;
    endfunction

    // Hold Reset for one cycle; return in the first FETCH cycle with Reset low
    task automatic apply_reset();
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
    endtask

    // Run one instruction to completion and compare against the model
    task automatic exec_instr(input logic [3:0] op, input logic iz, input logic ov);
        exp_t e;
        int cyc = 0, ir_w = 0, pc_w = 0, pc_src = 0, rw = 0, mw = 0, mr = 0;
        int aluw = 0, izw = 0, done = 0, dd = -1, da = -1, aluc = -1;
        int ir_idx = -1, excl = 0, hlt = 0;
        bit fin = 1'b0;
        e = model(op, iz);
        while (!fin && cyc < 40) begin
            opcode = op; isZero = iz; overflow_out = ov;
            @(negedge Clock);
            if (IR_Write) begin ir_w++; if (ir_idx < 0) ir_idx = cyc; end
            if (PC_Write) pc_w++;
            if (PC_Src) pc_src++;
            if (reg_write) begin rw++; dd = int'(destData); da = int'(destAddr); end
            if (Mwrite) mw++;
            if (Mread) mr++;
            if (ALUOutWrite) begin aluw++; aluc = int'(ALUcontrol); end
            if (iszero_write) izw++;
            if (halted) hlt++;
            if ((int'(IR_Write) + int'(reg_write) + int'(Mwrite)) > 1) excl++;
            if (instr_done) begin done++; fin = 1'b1; end
            cyc++;
            @(posedge Clock); #1;
        end
        n_tests++;
        if (cyc !== e.cycles) begin
            n_fail++; $display("FAIL op%h cycles: got %0d expected %0d", op, cyc, e.cycles);
        end
        n_tests++;
        if ({ir_w, pc_w, pc_src} !== {e.ir_w, e.pc_w, e.pc_src}) begin
            n_fail++; $display("FAIL op%h ir/pc/pcsrc counts: got %0d/%0d/%0d expected %0d/%0d/%0d",
                               op, ir_w, pc_w, pc_src, e.ir_w, e.pc_w, e.pc_src);
        end
        n_tests++;
        if ({rw, mw, mr} !== {e.rw, e.mw, e.mr}) begin
            n_fail++; $display("FAIL op%h rw/mw/mr counts: got %0d/%0d/%0d expected %0d/%0d/%0d",
                               op, rw, mw, mr, e.rw, e.mw, e.mr);
        end
        n_tests++;
        if ({aluw, izw, done} !== {e.aluw, e.izw, e.done}) begin
            n_fail++; $display("FAIL op%h aluw/izw/done counts: got %0d/%0d/%0d expected %0d/%0d/%0d",
                               op, aluw, izw, done, e.aluw, e.izw, e.done);
        end
        n_tests++;
        if ({dd, da, aluc} !== {e.dd, e.da, e.aluc}) begin
            n_fail++; $display("FAIL op%h destData/destAddr/ALUcontrol: got %0d/%0d/%0d expected %0d/%0d/%0d",
                               op, dd, da, aluc, e.dd, e.da, e.aluc);
        end
        n_tests++;
        if ({ir_idx, excl, hlt} !== {32'sd0, 32'sd0, 32'sd0}) begin
            n_fail++; $display("FAIL op%h ir_cycle/exclusive/halted: got %0d/%0d/%0d expected 0/0/0",
                               op, ir_idx, excl, hlt);
        end
    endtask

    // Outputs during reset, first fetch after release, reset mid-instruction
    task automatic test_reset();
        @(negedge Clock);
        n_tests++;
        if (all_out !== 27'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        @(posedge Clock); #1;
        Reset = 1'b0; opcode = 4'h0;
        @(negedge Clock);
        n_tests++;
        if ({IR_Write, PC_Write, state_dbg} !== {1'b1, 1'b1, 4'd0}) begin
            n_fail++; $display("FAIL first_fetch: got ir=%b pcw=%b st=%0d expected 1 1 0",
                               IR_Write, PC_Write, state_dbg);
        end
        @(posedge Clock); #1;
        @(negedge Clock);
        @(posedge Clock); #1;
        Reset = 1'b1;   // this cycle would be EXEC_R of the ADD
        @(negedge Clock);
        n_tests++;
        if (all_out !== 27'd0) begin
            n_fail++; $display("FAIL reset_cycle_outputs: got %h expected 0", all_out);
        end
        @(posedge Clock); #1;
        @(negedge Clock);
        n_tests++;
        if (all_out !== 27'd0) begin
            n_fail++; $display("FAIL after_reset_outputs: got %h expected 0", all_out);
        end
        @(posedge Clock); #1;
        Reset = 1'b0;
        @(negedge Clock);
        n_tests++;
        if ({IR_Write, PC_Write, PC_Src, state_dbg} !== {1'b1, 1'b1, 1'b0, 4'd0}) begin
            n_fail++; $display("FAIL release_fetch: got ir=%b pcw=%b pcs=%b st=%0d expected 1 1 0 0",
                               IR_Write, PC_Write, PC_Src, state_dbg);
        end
        @(posedge Clock); #1;
        apply_reset();
    endtask

    // ADD walks FETCH, DECODE, EXEC_R x2, ALU_WB
    task automatic test_add();
        int seq [5] = '{0, 1, 2, 2, 4};
        int bad = 0, dones = 0;
        for (int i = 0; i < 5; i++) begin
            opcode = 4'h0; isZero = 1'b0; overflow_out = 1'b0;
            @(negedge Clock);
            if (int'(state_dbg) != seq[i]) begin
                bad++; $display("FAIL add_state[%0d]: got %0d expected %0d", i, state_dbg, seq[i]);
            end
            if (instr_done) dones++;
            if (i == 3 && {ALUcontrol, ALUOutWrite, iszero_write} !== {3'd1, 1'b1, 1'b1}) begin
                bad++; $display("FAIL add_alu: got aluc=%0d aow=%b izw=%b expected 1 1 1",
                                ALUcontrol, ALUOutWrite, iszero_write);
            end
            if (i == 4 && {reg_write, destAddr, destData} !== {1'b1, 2'd1, 3'd0}) begin
                bad++; $display("FAIL add_wb: got rw=%b da=%0d dd=%0d expected 1 1 0",
                                reg_write, destAddr, destData);
            end
            @(posedge Clock); #1;
        end
        n_tests++;
        if (bad != 0) n_fail++;
        n_tests++;
        if (dones !== 1) begin
            n_fail++; $display("FAIL add_done_count: got %0d expected 1", dones);
        end
    endtask

    task automatic test_mem();
        exec_instr(4'h6, 1'b0, 1'b0);
        exec_instr(4'h7, 1'b1, 1'b0);
    endtask

    task automatic test_branch();
        exec_instr(4'h8, 1'b1, 1'b0);
        exec_instr(4'h8, 1'b0, 1'b0);
        exec_instr(4'h9, 1'b0, 1'b0);
    endtask

    task automatic test_illegal();
`ifdef CTRL_ILLEGAL_TRAP_EN
        int bad = 0;
        opcode = 4'hC; isZero = 1'b0; overflow_out = 1'b0;
        repeat (2) begin @(negedge Clock); @(posedge Clock); #1; end
        repeat (10) begin
            @(negedge Clock);
            if (state_dbg !== 4'd14 || halted !== 1'b1 || strobes !== 9'd0) bad++;
            @(posedge Clock); #1;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL illegal_trap: %0d bad cycles, last st=%0d halted=%b", bad, state_dbg, halted);
        end
        apply_reset();
        opcode = 4'h0; overflow_out = 1'b1;
        repeat (4) begin @(negedge Clock); @(posedge Clock); #1; end
        @(negedge Clock);
        n_tests++;
        if ({state_dbg, reg_write, halted} !== {4'd14, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL overflow_trap: got st=%0d rw=%b halted=%b expected 14 0 1",
                               state_dbg, reg_write, halted);
        end
        @(posedge Clock); #1;
        overflow_out = 1'b0;
        apply_reset();
`else
        exec_instr(4'hC, 1'b0, 1'b0);
        exec_instr(4'hB, 1'b1, 1'b1);
        exec_instr(4'h0, 1'b0, 1'b1);
`endif
    endtask

    // HALT holds with no strobes until reset
    task automatic test_halt();
        int bad = 0;
        opcode = 4'hF; isZero = 1'b0; overflow_out = 1'b0;
        repeat (2) begin @(negedge Clock); @(posedge Clock); #1; end
        repeat (20) begin
            @(negedge Clock);
            if (state_dbg !== 4'd13 || halted !== 1'b1 || strobes !== 9'd0 || instr_done !== 1'b0) bad++;
            @(posedge Clock); #1;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL halt_hold: %0d bad cycles, last st=%0d halted=%b strobes=%b",
                               bad, state_dbg, halted, strobes);
        end
        apply_reset();
    endtask

    // FETCH_WAIT = 3: IR_Write/PC_Write only on the 4th FETCH cycle
    task automatic test_fetch_wait();
        logic [4:0]  ir_vec, pcw_vec;
        logic [19:0] st_vec;
        apply_reset();
        opcode = 4'h0; isZero = 1'b0; overflow_out = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            ir_vec[i]       = f3_IR_Write;
            pcw_vec[i]      = f3_PC_Write;
            st_vec[i*4 +: 4] = f3_state_dbg;
            @(posedge Clock); #1;
        end
        n_tests++;
        if ({ir_vec, pcw_vec} !== {5'b01000, 5'b01000}) begin
            n_fail++; $display("FAIL fetch_wait_strobes: got ir=%b pcw=%b expected 01000 01000", ir_vec, pcw_vec);
        end
        n_tests++;
        if (st_vec !== 20'h10000) begin
            n_fail++; $display("FAIL fetch_wait_states: got %h expected 10000", st_vec);
        end
        apply_reset();
    endtask

    // Random instruction stream against the model
    task automatic test_random();
        logic [3:0] op;
        logic       iz, ov;
        for (int i = 0; i < 60; i++) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            op = 4'($urandom_range(0, 10));
            ov = 1'b0;
`else
            op = 4'($urandom_range(0, 14));
            ov = 1'($urandom_range(0, 1));
`endif
            iz = 1'($urandom_range(0, 1));
            exec_instr(op, iz, ov);
        end
    endtask

    initial begin
        Reset = 1'b1; opcode = 4'h0; isZero = 1'b0; overflow_out = 1'b0;
        @(posedge Clock); #1;
        test_reset();
        test_add();
        test_mem();
        test_branch();
        test_illegal();
        test_halt();
        test_fetch_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle FSM that drives the control inputs of the 16-bit accumulator datapath: register file, IR, A/B, ALU, ALUOut, accumulator and memory data register.
- It is the issuing end of the same control interface that the datapath consumes.
- It decodes IR[15:12] and sequences fetch, decode, execute, memory and writeback one state per clock.
- It sits between the IR and the datapath and closes the loop on isZero and overflow_out.

Parameters:
- FETCH_WAIT, 0, extra wait cycles held in FETCH before IR_Write (slow instruction memory); legal range 0-7.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- opcode  in  4  IR[15:12] from the datapath IR.
- isZero  in  1  registered zero flag from the datapath.
- overflow_out  in  1  ALU overflow from the datapath.
- IR_Write  out  1  load IR from Data_In.
- PC_Write  out  1  advance or load PC.
- PC_Src  out  1  0 = PC+1, 1 = branch/jump target.
- ItypeSel  out  1  immediate format select (0 = 8-bit, 1 = 12-bit).
- Asel  out  1  A source (1 = accumulator, 0 = register file).
- Bsel  out  1  B source (1 = immediate, 0 = register file).
- Awrite  out  1  load A.
- Bwrite  out  1  load B.
- ALUcontrol  out  3  ALU operation: 1 add, 2 sub, 3 and, 4 or.
- ALUOutWrite  out  1  load ALUOut.
- iszero_write  out  1  update isZero.
- reg_write  out  1  register file write.
- destAddr  out  2  write target (0 = register, 1 = accumulator).
- destData  out  3  write-data mux: 0 ALUOut, 2 B, 3 A, 4 memory data, 5 immediate.
- Mwrite  out  1  memory write.
- Mread  out  1  memory read into the memory data register.
- instr_done  out  1  one-cycle pulse on the last state of each instruction.
- halted  out  1  high while in HALT.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset
  - Reset sampled high at a rising edge: state <= FETCH, wait counter <= 0.
  - While Reset is high, every output is forced to 0; this includes ALUcontrol = 0, destData = 0 and destAddr = 0.
  - Reset wins over any state and aborts any instruction mid-sequence; no Mwrite or reg_write pulse occurs in the reset cycle.
- Output style: Moore outputs decoded from the state register (plus opcode in DECODE only). Every output not listed for a state is 0.
- State encoding: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ALU_WB=4, MEM_ADDR=5, MEM_RD=6, MEM_WB=7, MEM_WR=8, BRANCH=9, JUMP=10, MOVE=11, LOAD_IMM=12, HALT=13, TRAP=14.
- FETCH
  - Counter counts 0..FETCH_WAIT.
  - On the final count: IR_Write=1, PC_Write=1, PC_Src=0, then go to DECODE.
  - With FETCH_WAIT=0, FETCH lasts 1 cycle.
- DECODE: Asel=1, Awrite=1 (accumulator to A). Next state by opcode:
  - 0x0-0x3 (ADD/SUB/AND/OR) -> EXEC_R
  - 0x4 ADDI -> EXEC_I
  - 0x5 LI -> LOAD_IMM
  - 0x6 LW, 0x7 SW -> MEM_ADDR
  - 0x8 BEQZ -> BRANCH
  - 0x9 JMP -> JUMP
  - 0xA MOVE -> MOVE
  - 0xF HALT -> HALT
  - 0xB-0xE illegal, see Optional Feature.
- EXEC_R: Bsel=0, Bwrite=1 on entry. The following cycle applies ALUcontrol = opcode+1 with ALUOutWrite=1 and iszero_write=1. Two cycles total, then ALU_WB.
- EXEC_I: Bsel=1, ItypeSel=0, Bwrite=1, then an add cycle (ALUcontrol=1, ALUOutWrite=1, iszero_write=1), then ALU_WB.
- ALU_WB: reg_write=1, destAddr=1, destData=0, instr_done=1, then FETCH.
- LOAD_IMM: reg_write=1, destAddr=1, destData=5, instr_done=1, then FETCH.
- MOVE: reg_write=1, destAddr=0, destData=3, instr_done=1, then FETCH.
- MEM_ADDR: Bsel=1, Bwrite=1; one cycle of ALUcontrol=1 with ALUOutWrite=1. Then LW -> MEM_RD, SW -> MEM_WR.
- MEM_RD: Mread=1, then MEM_WB.
- MEM_WB: reg_write=1, destAddr=1, destData=4, instr_done=1, then FETCH.
- MEM_WR: Mwrite=1 for exactly one cycle, instr_done=1, then FETCH.
- BRANCH: PC_Src=1, PC_Write=isZero (isZero sampled this cycle), instr_done=1, then FETCH.
- JUMP: ItypeSel=1, PC_Src=1, PC_Write=1, instr_done=1, then FETCH.
- HALT: halted=1; all write strobes 0; remains in HALT until Reset.
- Exclusivity: at most one of reg_write, Mwrite, IR_Write is high in any cycle.
- overflow_out: ignored unless the Optional Feature is enabled.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Opcodes 0xB-0xE go to TRAP; TRAP holds until Reset with halted=1 and no strobes.
  - An ADD/SUB/ADDI with overflow_out=1 in its ALU cycle goes to TRAP instead of ALU_WB; the accumulator is left unwritten.
- Undefined: opcodes 0xB-0xE are NOPs: DECODE goes directly to FETCH with instr_done=1. Overflow is ignored and the TRAP state is unreachable.

Test Plan:
- Reset mid-instruction: Reset asserted while in EXEC_R -> next cycle state_dbg=0 and all outputs 0; after release the first IR_Write occurs in the first FETCH cycle (FETCH_WAIT=0).
- ADD (opcode 0x0) -> state sequence 0,1,2,2,4, i.e. FETCH/DECODE/EXEC_R(2 cycles)/ALU_WB; the ALU cycle shows ALUcontrol=1; ALU_WB shows reg_write=1, destAddr=1, destData=0; instr_done pulses once; 5 cycles total.
- LW (0x6) -> Mread for 1 cycle, then destData=4 with reg_write; 6 cycles total. SW (0x7) -> exactly one Mwrite pulse and zero reg_write pulses.
- BEQZ with isZero=1 -> PC_Write=1, PC_Src=1 in BRANCH. BEQZ with isZero=0 -> PC_Write=0.
- Opcode 0xC -> with CTRL_ILLEGAL_TRAP_EN: state 14 and halted=1 stuck until Reset. Without it: back to FETCH after DECODE with instr_done=1.
- FETCH_WAIT=3 -> IR_Write rises on the 4th FETCH cycle only; HALT (0xF) -> halted=1, no strobes for 20 cycles.
